mem_io_sequencer: RTL and testbench
===================================

Name: mem_io_sequencer

Overview:
- Fabric-side controller for the HPS memory I/O export channel.
- Decodes 32-bit control words from the HPS and buffers 128-bit input beats in a FIFO.
- Streams the buffered beats into a compute kernel and returns kernel results to the HPS over the output channel, honouring waitrequest back-pressure.
- Counts beats and reports busy/done/overflow status for a job of programmable length.

Parameters:
FIFO_DEPTH, 8, input FIFO entries; power of two, >= 2
LEN_W, 16, width of job length and beat counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ctrl_data  in  32  control word; [31:28] opcode, [27:0] argument
ctrl_set  in  1  ctrl_data valid this cycle (single-cycle strobe)
in_data  in  128  input beat from HPS
in_set  in  1  in_data valid this cycle; no back-pressure
out_data  out  128  result beat to HPS
out_set  out  1  out_data valid
out_waitrequest  in  1  HPS stall; transfer completes on out_set && !out_waitrequest
k_in_data  out  128  beat to kernel
k_in_valid  out  1  k_in_data valid
k_in_ready  in  1  kernel accepts beat
k_out_data  in  128  kernel result
k_out_valid  in  1  k_out_data valid
k_out_ready  out  1  sequencer accepts result
busy  out  1  state is RUN or FLUSH
done  out  1  state is DONE
overflow  out  1  sticky: input beat dropped
beat_count  out  LEN_W  result beats delivered to HPS in the current job

Behaviour:
- Reset: state IDLE, FIFO empty, len=0, counters=0, out_set=0, out_data=0, k_in_valid=0, busy=0, done=0, overflow=0.
- Opcodes (ctrl_set=1):
  - 0x1 SET_LEN: len = arg[LEN_W-1:0]; ignored in RUN/FLUSH.
  - 0x2 START: accepted in IDLE/DONE; clears counters, done and overflow; next state RUN, or DONE if len==0.
  - 0x3 ABORT: accepted in RUN; next state FLUSH.
  - Any other opcode, or an opcode outside its states, is a no-op.
- States:
  - IDLE -> RUN on START.
  - RUN -> DONE when a result transfer completes and brings beat_count to len. RUN -> FLUSH on ABORT.
  - FLUSH: FIFO cleared in the cycle ABORT is decoded; k_in_valid=0; k_out_ready=0. Stays until out_set==0, then IDLE.
  - DONE -> RUN/DONE on START.
- Input path:
  - in_set in RUN with FIFO not full and in_count<len: push, in_count++.
  - Otherwise (FIFO full, in_count==len, or state != RUN): beat dropped, overflow=1.
  - ctrl_set and in_set in the same cycle: the beat is judged against the pre-command state. In IDLE, START plus beat drops the beat and sets overflow, but START's clear of overflow takes priority in that cycle.
- FIFO:
  - First-word-fall-through; k_in_valid = !empty && state==RUN; k_in_data = head.
  - Pop on k_in_valid && k_in_ready.
  - Simultaneous push and pop when full is not allowed: full means dropped.
  - Pointer wrap modulo FIFO_DEPTH; a separate occupancy counter distinguishes full from empty.
- Output path:
  - One-entry register. k_out_ready = (state==RUN) && (!out_set || !out_waitrequest).
  - On k_out_valid && k_out_ready: out_data loaded, out_set=1, same cycle as any completing transfer (back-to-back, full throughput).
  - While out_set && out_waitrequest: out_data and out_set held stable.
  - On completion with no new load: out_set=0.
  - beat_count increments on each completed transfer.
- Latency: in_set to k_in_valid is 1 cycle. k_out_valid to out_set is 1 cycle.
- Counters saturate at len; extra kernel results are never accepted because k_out_ready is low outside RUN.
- Reset mid-job returns to IDLE in one cycle, discarding FIFO and output contents.

Test Plan:
- SET_LEN 4, START, 4 in_set beats 0x1..0x4; kernel is a pass-through with ready=1; waitrequest=0 -> out_data 0x1..0x4 on 4 consecutive cycles, beat_count=4, done=1, busy=0.
- FIFO_DEPTH=8, len=12, k_in_ready=0, 9 beats -> FIFO holds 8, 9th dropped, overflow=1; release ready -> exactly 8 results.
- len=3, waitrequest held high 5 cycles on the first result -> out_data/out_set stable all 5 cycles, k_out_ready=0, beat_count still 0; then 3 transfers complete.
- ABORT while out_set=1 and waitrequest=1 -> FLUSH, FIFO empty; after waitrequest drops, transfer completes, state IDLE, done=0.
- SET_LEN 0 then START -> DONE next cycle, beat_count=0; in_set in IDLE -> overflow=1; following START clears overflow.
- reset asserted in RUN with 3 beats queued -> next cycle all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/mem_io_sequencer_if.sv
// HPS memory I/O export channel plus kernel stream and status, bundled for the sequencer.
// The slave modport is the sequencer's view; master is the HPS/kernel side.
interface mem_io_sequencer_if #(
   parameter int LEN_W = 16
) ();
   logic [31:0]      ctrl_data;
   logic             ctrl_set;
   logic [127:0]     in_data;
   logic             in_set;
   logic [127:0]     out_data;
   logic             out_set;
   logic             out_waitrequest;
   logic [127:0]     k_in_data;
   logic             k_in_valid;
   logic             k_in_ready;
   logic [127:0]     k_out_data;
   logic             k_out_valid;
   logic             k_out_ready;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [LEN_W-1:0] beat_count;

   modport slave (
      input  ctrl_data, ctrl_set, in_data, in_set, out_waitrequest,
             k_in_ready, k_out_data, k_out_valid,
      output out_data, out_set, k_in_data, k_in_valid, k_out_ready,
             busy, done, overflow, beat_count
   );

   modport master (
      output ctrl_data, ctrl_set, in_data, in_set, out_waitrequest,
             k_in_ready, k_out_data, k_out_valid,
      input  out_data, out_set, k_in_data, k_in_valid, k_out_ready,
             busy, done, overflow, beat_count
   );
endinterface

// File: rtl/mem_io_sequencer.sv
// Fabric-side sequencer: decodes HPS control words, buffers input beats in a FWFT FIFO,
// feeds a compute kernel and returns its results through a one-entry output register.
module mem_io_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16
) (
   input logic                clk,
   input logic                reset,
   mem_io_sequencer_if.slave  io
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [3:0] OP_SET_LEN = 4'h1;
   localparam logic [3:0] OP_START   = 4'h2;
   localparam logic [3:0] OP_ABORT   = 4'h3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] in_count_q, in_count_d;
   logic [LEN_W-1:0] beat_count_q, beat_count_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             out_set_q, out_set_d;
   logic [127:0]     out_data_q, out_data_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [127:0]     mem [FIFO_DEPTH];

   logic [3:0] opcode;
   logic       idle_or_done, do_set_len, do_start, do_abort;
   logic       k_in_valid, k_out_ready, push, pop, load, xfer;
   logic       unused_ctrl;

   // Only the low LEN_W argument bits carry meaning.
   assign unused_ctrl = ^io.ctrl_data;

   assign opcode       = io.ctrl_data[31:28];
   assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
   assign do_set_len   = io.ctrl_set && (opcode == OP_SET_LEN) && idle_or_done;
   assign do_start     = io.ctrl_set && (opcode == OP_START) && idle_or_done;
   assign do_abort     = io.ctrl_set && (opcode == OP_ABORT) && (state_q == S_RUN);

   assign k_in_valid  = (count_q != '0) && (state_q == S_RUN);
   assign k_out_ready = (state_q == S_RUN) && (!out_set_q || !io.out_waitrequest);
   assign pop         = k_in_valid && io.k_in_ready;
   assign load        = io.k_out_valid && k_out_ready;
   assign xfer        = out_set_q && !io.out_waitrequest;
   assign push        = io.in_set && (state_q == S_RUN) &&
                        (count_q != CNT_W'(FIFO_DEPTH)) && (in_count_q < len_q);

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block can infer a latch.
      state_d      = state_q;
      len_d        = len_q;
      in_count_d   = in_count_q;
      beat_count_d = beat_count_q;
      overflow_d   = overflow_q;
      out_set_d    = out_set_q;
      out_data_d   = out_data_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;

      if (push) begin
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         in_count_d = in_count_q + LEN_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (io.in_set && !push) overflow_d = 1'b1;

      if (load) begin
         out_data_d = io.k_out_data;
         out_set_d  = 1'b1;
      end else if (xfer) begin
         out_set_d  = 1'b0;
      end
      if (xfer && (beat_count_q < len_q)) beat_count_d = beat_count_q + LEN_W'(1);

      if (do_set_len) len_d = io.ctrl_data[LEN_W-1:0];

      unique case (state_q)
         S_RUN: begin
            if (do_abort) begin
               state_d  = S_FLUSH;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               count_d  = '0;
            end else if (xfer && (beat_count_d == len_q)) begin
               state_d = S_DONE;
            end
         end
         // The pending result is still allowed to drain to the HPS before going idle.
         S_FLUSH: if (!out_set_q) state_d = S_IDLE;
         default: ;
      endcase

      // START's clear wins over a beat dropped in the same cycle.
      if (do_start) begin
         state_d      = (len_q == '0) ? S_DONE : S_RUN;
         in_count_d   = '0;
         beat_count_d = '0;
         overflow_d   = 1'b0;
      end
   end

   assign busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
   assign done_d = (state_d == S_DONE);

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (reset) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         in_count_q   <= '0;
         beat_count_q <= '0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         out_set_q    <= 1'b0;
         out_data_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         in_count_q   <= in_count_d;
         beat_count_q <= beat_count_d;
         overflow_q   <= overflow_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         out_set_q    <= out_set_d;
         out_data_q   <= out_data_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // NOTE: FIFO storage has no reset; the occupancy counter alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= io.in_data;
   end

   assign io.k_in_data   = mem[rd_ptr_q];
   assign io.k_in_valid  = k_in_valid;
   assign io.k_out_ready = k_out_ready;
   assign io.out_data    = out_data_q;
   assign io.out_set     = out_set_q;
   assign io.busy        = busy_q;
   assign io.done        = done_q;
   assign io.overflow    = overflow_q;
   assign io.beat_count  = beat_count_q;
endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed bench for mem_io_sequencer with a lossless pass-through kernel model.
module tb_mem_io_sequencer;
   localparam int FIFO_DEPTH = 8;
   localparam int LEN_W      = 16;
   localparam logic [3:0] OP_SET_LEN = 4'h1;
   localparam logic [3:0] OP_START   = 4'h2;
   localparam logic [3:0] OP_ABORT   = 4'h3;

   logic clk = 1'b0;
   logic reset;
   logic k_gate;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   logic [127:0] rx_data [$];
   int           rx_cyc  [$];

   always #5 clk = ~clk;

   mem_io_sequencer_if #(.LEN_W(LEN_W)) ifc ();

   mem_io_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (ifc)
   );

   // Pass-through kernel; k_gate=0 stalls it in both directions.
   assign ifc.k_out_data  = ifc.k_in_data;
   assign ifc.k_out_valid = ifc.k_in_valid && k_gate;
   assign ifc.k_in_ready  = ifc.k_out_ready && k_gate;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset === 1'b0 && ifc.out_set === 1'b1 && ifc.out_waitrequest === 1'b0) begin
         rx_data.push_back(ifc.out_data);
         rx_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl(input logic [3:0] op, input logic [27:0] arg);
      ifc.ctrl_data = {op, arg};
      ifc.ctrl_set  = 1'b1;
      step();
      ifc.ctrl_set  = 1'b0;
   endtask

   task automatic send_beats(input int n, input logic [127:0] base);
      for (int i = 0; i < n; i++) begin
         ifc.in_data = base + 128'(i);
         ifc.in_set  = 1'b1;
         step();
      end
      ifc.in_set = 1'b0;
   endtask

   task automatic check_reset_state(input string p);
      check({p, "_out_set"},     ifc.out_set, 1'b0);
      check({p, "_out_data"},    ifc.out_data, 128'h0);
      check({p, "_k_in_valid"},  ifc.k_in_valid, 1'b0);
      check({p, "_k_out_ready"}, ifc.k_out_ready, 1'b0);
      check({p, "_busy"},        ifc.busy, 1'b0);
      check({p, "_done"},        ifc.done, 1'b0);
      check({p, "_overflow"},    ifc.overflow, 1'b0);
      check({p, "_beat_count"},  ifc.beat_count, 0);
   endtask

   initial begin
      int base;
      reset               = 1'b1;
      k_gate              = 1'b0;
      ifc.ctrl_data       = '0;
      ifc.ctrl_set        = 1'b0;
      ifc.in_data         = '0;
      ifc.in_set          = 1'b0;
      ifc.out_waitrequest = 1'b0;
      step();
      step();
      check_reset_state("rst");
      reset = 1'b0;
      step();

      // Basic job: 4 beats, free-running kernel and HPS.
      k_gate = 1'b1;
      ctrl(OP_SET_LEN, 28'd4);
      ctrl(OP_START, 28'd0);
      check("t1_busy_run", ifc.busy, 1'b1);
      send_beats(4, 128'h1);
      for (int i = 0; i < 20 && ifc.done !== 1'b1; i++) step();
      check("t1_done", ifc.done, 1'b1);
      check("t1_busy", ifc.busy, 1'b0);
      check("t1_beat_count", ifc.beat_count, 4);
      check("t1_overflow", ifc.overflow, 1'b0);
      check("t1_rx_n", rx_data.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t1_rx%0d", i), rx_data[i], 128'(i + 1));
      check("t1_back_to_back", rx_cyc[3] - rx_cyc[0], 3);

      // Overflow: kernel stalled, 9 beats into an 8-deep FIFO.
      k_gate = 1'b0;
      ctrl(OP_SET_LEN, 28'd12);
      ctrl(OP_START, 28'd0);
      send_beats(9, 128'h101);
      check("t2_overflow", ifc.overflow, 1'b1);
      check("t2_k_in_valid", ifc.k_in_valid, 1'b1);
      base = rx_data.size();
      k_gate = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check("t2_rx_n", rx_data.size() - base, 8);
      check("t2_rx_first", rx_data[base], 128'h101);
      check("t2_rx_last", rx_data[base + 7], 128'h108);
      check("t2_beat_count", ifc.beat_count, 8);
      check("t2_still_run", ifc.busy, 1'b1);
      ctrl(OP_ABORT, 28'd0);
      for (int i = 0; i < 10 && ifc.busy !== 1'b0; i++) step();
      check("t2_idle", ifc.busy, 1'b0);

      // Back-pressure: first result held for 5 cycles.
      ifc.out_waitrequest = 1'b1;
      ctrl(OP_SET_LEN, 28'd3);
      ctrl(OP_START, 28'd0);
      check("t3_overflow_cleared", ifc.overflow, 1'b0);
      send_beats(3, 128'h11);
      base = rx_data.size();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_hold_set%0d", i), ifc.out_set, 1'b1);
         check($sformatf("t3_hold_data%0d", i), ifc.out_data, 128'h11);
         check($sformatf("t3_hold_kready%0d", i), ifc.k_out_ready, 1'b0);
         check($sformatf("t3_hold_count%0d", i), ifc.beat_count, 0);
         step();
      end
      ifc.out_waitrequest = 1'b0;
      for (int i = 0; i < 20 && ifc.done !== 1'b1; i++) step();
      check("t3_done", ifc.done, 1'b1);
      check("t3_rx_n", rx_data.size() - base, 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("t3_rx%0d", i), rx_data[base + i], 128'h11 + 128'(i));

      // ABORT while a result is stalled and a beat is still queued.
      ifc.out_waitrequest = 1'b1;
      ctrl(OP_START, 28'd0);
      send_beats(2, 128'h41);
      ctrl(OP_ABORT, 28'd0);
      check("t4_flush_busy", ifc.busy, 1'b1);
      check("t4_flush_kin", ifc.k_in_valid, 1'b0);
      check("t4_flush_kready", ifc.k_out_ready, 1'b0);
      check("t4_flush_set", ifc.out_set, 1'b1);
      check("t4_flush_data", ifc.out_data, 128'h41);
      base = rx_data.size();
      ifc.out_waitrequest = 1'b0;
      for (int i = 0; i < 10 && ifc.busy !== 1'b0; i++) step();
      check("t4_idle", ifc.busy, 1'b0);
      check("t4_done", ifc.done, 1'b0);
      check("t4_out_set", ifc.out_set, 1'b0);
      check("t4_rx_n", rx_data.size() - base, 1);
      check("t4_rx", rx_data[base], 128'h41);
      ctrl(OP_SET_LEN, 28'd2);
      ctrl(OP_START, 28'd0);
      step();
      step();
      check("t4_fifo_empty", ifc.k_in_valid, 1'b0);
      ctrl(OP_ABORT, 28'd0);
      for (int i = 0; i < 10 && ifc.busy !== 1'b0; i++) step();

      // Zero-length job, drop in IDLE, START clearing overflow in the same cycle.
      send_beats(1, 128'h77);
      check("t5_idle_drop", ifc.overflow, 1'b1);
      ctrl(OP_SET_LEN, 28'd0);
      ifc.in_data = 128'h78;
      ifc.in_set  = 1'b1;
      ctrl(OP_START, 28'd0);
      ifc.in_set  = 1'b0;
      check("t5_done", ifc.done, 1'b1);
      check("t5_busy", ifc.busy, 1'b0);
      check("t5_beat_count", ifc.beat_count, 0);
      check("t5_overflow_clear", ifc.overflow, 1'b0);

      // Reset mid-job with 3 beats queued.
      k_gate = 1'b0;
      ctrl(OP_SET_LEN, 28'd5);
      ctrl(OP_START, 28'd0);
      send_beats(3, 128'h91);
      check("t6_queued", ifc.k_in_valid, 1'b1);
      reset = 1'b1;
      step();
      check_reset_state("t6");
      reset = 1'b0;
      ctrl(OP_START, 28'd0);
      check("t6_len_cleared", ifc.done, 1'b1);
      base = rx_data.size();
      k_gate = 1'b1;
      ctrl(OP_SET_LEN, 28'd5);
      ctrl(OP_START, 28'd0);
      for (int i = 0; i < 4; i++) step();
      check("t6_fifo_empty", ifc.k_in_valid, 1'b0);
      check("t6_no_rx", rx_data.size() - base, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
